// File: rtl/ecp5pll_phase_ctrl.sv
// ecp5pll_phase_ctrl: sequencer for the ECP5 PLL dynamic phase-shift pins.
// Takes signed fine-step move requests per channel, emits timed phasestep
// pulses, and tracks each channel's phase position modulo one revolution.
// A lock drop mid-move aborts the move and raises the sticky error flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a request; ready when locked and no error
// S_SETUP | phasesel/phasedir settling before the first pulse
// S_HI    | phasestep high; last cycle commits one step
// S_LO    | phasestep low gap between pulses
// S_DONE  | one-cycle completion strobe
module ecp5pll_phase_ctrl #(
  parameter int CHANNELS   = 4,
  parameter int PHASE_BITS = 10,
  parameter int REV0       = 8,
  parameter int REV1       = 8,
  parameter int REV2       = 8,
  parameter int REV3       = 8,
  parameter int SETUP_CYC  = 2,
  parameter int STEP_HI    = 2,
  parameter int STEP_LO    = 2
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    locked_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [1:0]              req_ch_i,
  input  logic [PHASE_BITS-1:0]   req_steps_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  input  logic                    err_clr_i,
  output logic [4*PHASE_BITS-1:0] pos_o,
  output logic [1:0]              phasesel_o,
  output logic                    phasedir_o,
  output logic                    phasestep_o,
  output logic                    phaseloadreg_o
);

  localparam int TMAX = (SETUP_CYC > STEP_HI) ? ((SETUP_CYC > STEP_LO) ? SETUP_CYC : STEP_LO)
                                              : ((STEP_HI > STEP_LO) ? STEP_HI : STEP_LO);
  localparam int TW = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] T_HI    = TW'(STEP_HI - 1);
  localparam logic [TW-1:0] T_LO    = TW'(STEP_LO - 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [2:0]    CH_LIM  = 3'(CHANNELS);
  localparam logic [PHASE_BITS:0] R_ONE = (PHASE_BITS+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HI, S_LO, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  lock_meta, lock_sync;
  logic [TW-1:0]         tmr;
  logic [PHASE_BITS:0]   rem;
  logic [PHASE_BITS:0]   req_ext, req_mag;
  logic                  err_q;
  logic                  accept, ch_ok, tmr_tc, in_move, abort, step_done, err_set;

  assign req_ext   = {req_steps_i[PHASE_BITS-1], req_steps_i};
  assign req_mag   = req_ext[PHASE_BITS] ? (~req_ext + R_ONE) : req_ext;
  assign ch_ok     = ({1'b0, req_ch_i} < CH_LIM);
  assign accept    = req_valid_i & req_ready_o;
  assign tmr_tc    = (tmr == '0);
  assign in_move   = (state_q == S_SETUP) | (state_q == S_HI) | (state_q == S_LO);
  assign abort     = in_move & ~lock_sync;
  assign step_done = (state_q == S_HI) & tmr_tc & lock_sync;
  assign err_set   = (accept & ~ch_ok) | abort;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= locked_i;
      lock_sync <= lock_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic; lock loss takes priority over any timer expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && ch_ok) state_d = (req_mag == '0) ? S_DONE : S_SETUP;
      end
      S_SETUP: begin
        if (!lock_sync)  state_d = S_IDLE;
        else if (tmr_tc) state_d = S_HI;
      end
      S_HI: begin
        if (!lock_sync)  state_d = S_IDLE;
        else if (tmr_tc) state_d = (rem == R_ONE) ? S_DONE : S_LO;
      end
      S_LO: begin
        if (!lock_sync)  state_d = S_IDLE;
        else if (tmr_tc) state_d = S_HI;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; phasestep is gated by lock so it drops in the abort cycle.
  always_comb begin
    req_ready_o = (state_q == S_IDLE) & lock_sync & ~err_q;
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    phasestep_o = (state_q == S_HI) & lock_sync;
  end

  assign err_o          = err_q;
  assign phaseloadreg_o = 1'b0;

  // Phase timer (down-counter, reloaded on every state change), remaining
  // step count, latched channel/direction, and sticky error (set wins).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tmr        <= '0;
      rem        <= '0;
      phasesel_o <= '0;
      phasedir_o <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        case (state_d)
          S_SETUP: tmr <= T_SETUP;
          S_HI:    tmr <= T_HI;
          S_LO:    tmr <= T_LO;
          default: tmr <= '0;
        endcase
      end else if (!tmr_tc) begin
        tmr <= tmr - T_ONE;
      end
      if (accept && ch_ok) rem <= req_mag;
      else if (step_done)  rem <= rem - R_ONE;
      if (accept && ch_ok && (req_mag != '0)) begin
        phasesel_o <= req_ch_i;
        phasedir_o <= ~req_steps_i[PHASE_BITS-1];
      end
      err_q <= err_set | (err_q & ~err_clr_i);
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_pos
    localparam int REV_C = (c == 0) ? REV0 : (c == 1) ? REV1 : (c == 2) ? REV2 : REV3;
    localparam logic [PHASE_BITS-1:0] LAST_C = PHASE_BITS'(REV_C - 1);
    localparam logic [PHASE_BITS-1:0] P_ONE  = PHASE_BITS'(1);
    localparam logic [1:0]            CH_ID  = 2'(c);
    logic [PHASE_BITS-1:0] pos_c;

    // Per-channel position, modulo the channel's revolution length.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        pos_c <= '0;
      end else if (step_done && (phasesel_o == CH_ID) && (c < CHANNELS)) begin
        if (phasedir_o) pos_c <= (pos_c == LAST_C) ? '0 : pos_c + P_ONE;
        else            pos_c <= (pos_c == '0) ? LAST_C : pos_c - P_ONE;
      end
    end

    assign pos_o[c*PHASE_BITS +: PHASE_BITS] = pos_c;
  end

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Directed bench for ecp5pll_phase_ctrl: a table of moves with hand-computed
// pulse counts and positions, then hand sequences for invalid channel, lock
// loss, held request and asynchronous reset mid-move.
module tb_ecp5pll_phase_ctrl;
  localparam int PB    = 10;
  localparam int SETUP = 2;
  localparam int HI    = 2;
  localparam int LO    = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          locked = 1'b1;
  logic          req_valid = 1'b0;
  logic          err_clr = 1'b0;
  logic [1:0]    req_ch = '0;
  logic [PB-1:0] req_steps = '0;
  logic          req_ready, busy, done, err;
  logic [4*PB-1:0] pos;
  logic [1:0]    phasesel;
  logic          phasedir, phasestep, phaseloadreg;

  ecp5pll_phase_ctrl #(
    .CHANNELS(3), .PHASE_BITS(PB), .REV0(56), .REV1(8), .REV2(8), .REV3(8),
    .SETUP_CYC(SETUP), .STEP_HI(HI), .STEP_LO(LO)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .locked_i(locked),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_ch_i(req_ch),
    .req_steps_i(req_steps), .busy_o(busy), .done_o(done), .err_o(err),
    .err_clr_i(err_clr), .pos_o(pos), .phasesel_o(phasesel),
    .phasedir_o(phasedir), .phasestep_o(phasestep), .phaseloadreg_o(phaseloadreg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [39:0] pk(input int p0, input int p1, input int p2);
    return {10'd0, 10'(p2), 10'(p1), 10'(p0)};
  endfunction

  typedef struct {
    logic [1:0]  ch;
    int          steps;
    int          n;
    logic        dir;
    logic [39:0] pos;
  } vec_t;

  vec_t vecs[8];

  task automatic run_move(input string tag, input logic [1:0] ch, input int steps,
                          input int n, input logic dir, input logic [39:0] exp_pos);
    int b, exp_k, done_k, rises, hi_cyc, busy_cyc, bad_sel, viol;
    logic prev;
    exp_k = (n == 0) ? 1 : SETUP + n*HI + (n-1)*LO + 1;
    b = 0;
    while (!req_ready && b < 20) begin
      @(negedge clk);
      b++;
    end
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_ch = ch;
    req_steps = 10'(steps);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    done_k = 0; rises = 0; hi_cyc = 0; busy_cyc = 0; bad_sel = 0; viol = 0; prev = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      if (busy) busy_cyc++;
      if (busy && req_ready) viol++;
      if (phasestep) begin
        hi_cyc++;
        if (!prev) rises++;
        if (phasesel !== ch || phasedir !== dir) bad_sel++;
      end
      prev = phasestep;
      if (done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_cycle"}, 64'(done_k), 64'(exp_k));
    check({tag, "_pulses"}, 64'(rises), 64'(n));
    check({tag, "_hi_cycles"}, 64'(hi_cyc), 64'(n*HI));
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_k));
    check({tag, "_sel_dir"}, 64'(bad_sel), 64'd0);
    check({tag, "_ready_busy"}, 64'(viol), 64'd0);
    check({tag, "_pos"}, 64'(pos), 64'(exp_pos));
    check({tag, "_err"}, 64'(err), 64'd0);
    @(negedge clk);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, last_hi, dones, accepts, viol, first_done, n_done, b;
    logic prev, ready6;

    vecs[0] = '{ch: 2'd1, steps:    3, n:   3, dir: 1'b1, pos: pk( 0, 3, 0)};
    vecs[1] = '{ch: 2'd2, steps:    6, n:   6, dir: 1'b1, pos: pk( 0, 3, 6)};
    vecs[2] = '{ch: 2'd2, steps:    5, n:   5, dir: 1'b1, pos: pk( 0, 3, 3)};
    vecs[3] = '{ch: 2'd2, steps:   -4, n:   4, dir: 1'b0, pos: pk( 0, 3, 7)};
    vecs[4] = '{ch: 2'd0, steps:    0, n:   0, dir: 1'b1, pos: pk( 0, 3, 7)};
    vecs[5] = '{ch: 2'd1, steps:   -1, n:   1, dir: 1'b0, pos: pk( 0, 2, 7)};
    vecs[6] = '{ch: 2'd0, steps: -512, n: 512, dir: 1'b0, pos: pk(48, 2, 7)};
    vecs[7] = '{ch: 2'd0, steps:   60, n:  60, dir: 1'b1, pos: pk(52, 2, 7)};

    // Reset state
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_pos", 64'(pos), 64'd0);
    check("rst_sel", 64'(phasesel), 64'd0);
    check("rst_dir", 64'(phasedir), 64'd0);
    check("rst_step", 64'(phasestep), 64'd0);
    check("rst_loadreg", 64'(phaseloadreg), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("sync_lat1_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("sync_lat2_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 8; i++)
      run_move($sformatf("v%0d", i), vecs[i].ch, vecs[i].steps, vecs[i].n, vecs[i].dir, vecs[i].pos);

    // Invalid channel, with err_clr in the same cycle: the set must win
    @(negedge clk);
    req_ch = 2'd3; req_steps = 10'd2; req_valid = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; err_clr = 1'b0;
    check("badch_err", 64'(err), 64'd1);
    rises = 0;
    for (int k = 0; k < 8; k++) begin
      if (phasestep || busy) rises++;
      @(negedge clk);
    end
    check("badch_activity", 64'(rises), 64'd0);
    check("badch_pos", 64'(pos), 64'(pk(52, 2, 7)));
    check("badch_ready", 64'(req_ready), 64'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("badch_clr_err", 64'(err), 64'd0);
    check("badch_clr_ready", 64'(req_ready), 64'd1);

    // Lock loss: the drop is timed so the synchronised lock falls in the
    // last cycle of the 2nd high phase, cutting that pulse short.
    req_ch = 2'd1; req_steps = 10'd4; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rises = 0; last_hi = 0; dones = 0; prev = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (phasestep) begin
        last_hi = k;
        if (!prev) rises++;
      end
      prev = phasestep;
      if (done) dones++;
      if (k == 6) locked = 1'b0;
      @(negedge clk);
    end
    check("lock_pulses", 64'(rises), 64'd2);
    check("lock_last_hi", 64'(last_hi), 64'd7);
    check("lock_no_done", 64'(dones), 64'd0);
    check("lock_err", 64'(err), 64'd1);
    check("lock_busy", 64'(busy), 64'd0);
    check("lock_pos", 64'(pos), 64'(pk(52, 3, 7)));
    locked = 1'b1;
    repeat (6) @(negedge clk);
    check("lock_ready_held", 64'(req_ready), 64'd0);
    check("lock_err_held", 64'(err), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("lock_clr_err", 64'(err), 64'd0);
    check("lock_clr_ready", 64'(req_ready), 64'd1);

    // Held request: one accept per move, back-to-back from the IDLE cycle
    req_ch = 2'd1; req_steps = 10'd1; req_valid = 1'b1;
    accepts = 0; viol = 0; first_done = -1; n_done = 0; ready6 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (req_valid && req_ready) accepts++;
      if (busy && req_ready) viol++;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end
      if (i == 6) ready6 = req_ready;
      if (i == 11) req_valid = 1'b0;
      @(negedge clk);
    end
    check("hold_accepts", 64'(accepts), 64'd2);
    check("hold_ready_busy", 64'(viol), 64'd0);
    check("hold_first_done", 64'(first_done), 64'd5);
    check("hold_ready_after_done", 64'(ready6), 64'd1);
    check("hold_dones", 64'(n_done), 64'd2);
    check("hold_pos", 64'(pos), 64'(pk(52, 5, 7)));

    // Asynchronous reset in the middle of a pulse
    @(negedge clk);
    req_ch = 2'd0; req_steps = 10'd3; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    b = 0;
    while (!phasestep && b < 20) begin
      @(negedge clk);
      b++;
    end
    check("arst_pulse_seen", 64'(phasestep), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_step", 64'(phasestep), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_pos", 64'(pos), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_ready", 64'(req_ready), 64'd1);
    check("arst_err", 64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
